// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: receives a little-endian word-count header plus program
// words as a byte stream, writes them to instruction memory, and gates CPU reset.
module imem_boot_ctrl #(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic               byte_ready_q, byte_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               xfer;
  logic [CNT_W-1:0]   hdr_count;

  assign xfer      = byte_valid && byte_ready_q;
  assign hdr_count = {byte_data, count_q[7:0]};

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    byte_ready_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          cpu_rst_d  = 1'b1;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_d[7:0] = byte_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d    = hdr_count;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (hdr_count == '0) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else if (32'(hdr_count) > MEM_SIZE) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              state_d     = S_WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = {byte_data, word_q};
              mem_addr_d  = 32'({word_idx_q, 2'b00});
            end
          endcase
        end
      end
      S_WRITE: begin
        if (CNT_W'(word_idx_q) == count_q - 16'd1) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // byte_ready follows the state being entered so it is valid in that state
    byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: header bounds, stalled host, restart,
// reset mid-load; writes captured by a monitor and checked against hand values.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int ready_in_write = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  imem_boot_ctrl #(.MEM_SIZE(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Capture every write strobe; byte_ready must be low in the write cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (byte_ready !== 1'b0) ready_in_write++;
    end
  end

  function automatic logic [31:0] get_addr(input int i);
    if (i < wr_addr.size()) return wr_addr[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed=byte_ready low expected=high");
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bit stall);
    foreach (stream[i]) send_byte(stream[i], stall);
  endtask

  task automatic new_load();
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $error("FAIL end_timeout: observed=no done/error expected=done or error");
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int nbad;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Reset, then idle for 20 cycles
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_reset_vals("idle");
    chk("idle_writes", 32'(wr_addr.size()), 32'd0);

    // Two-word load with valid held high
    new_load();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(byte_ready), 32'd1);
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
    send_stream(1'b0);
    wait_end();
    chk("two_nwr", 32'(wr_addr.size()), 32'd2);
    chk("two_addr0", get_addr(0), 32'h0);
    chk("two_data0", get_data(0), 32'h00A0_0513);
    chk("two_addr1", get_addr(1), 32'h4);
    chk("two_data1", get_data(1), 32'h00B5_05B3);
    chk("two_done", 32'(done), 32'd1);
    chk("two_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("two_busy", 32'(busy), 32'd0);

    // Same stream with a stalling host, restarted from DONE
    new_load();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    send_stream(1'b1);
    wait_end();
    chk("stall_nwr", 32'(wr_addr.size()), 32'd2);
    chk("stall_addr0", get_addr(0), 32'h0);
    chk("stall_data0", get_data(0), 32'h00A0_0513);
    chk("stall_addr1", get_addr(1), 32'h4);
    chk("stall_data1", get_data(1), 32'h00B5_05B3);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_cpu_rst", 32'(cpu_rst), 32'd0);

    // Header of 257 words is rejected
    new_load();
    stream = '{8'h01, 8'h01};
    send_stream(1'b0);
    wait_end();
    chk("over_error", 32'(error), 32'd1);
    chk("over_done", 32'(done), 32'd0);
    chk("over_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_ready", 32'(byte_ready), 32'd0);
    chk("over_nwr", 32'(wr_addr.size()), 32'd0);

    // Zero-length load completes without writes
    new_load();
    chk("from_err_clr", 32'(error), 32'd0);
    stream = '{8'h00, 8'h00};
    send_stream(1'b0);
    wait_end();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // Full-memory load of 256 words
    new_load();
    stream = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      w = 32'hC0DE_0000 | 32'(i);
      stream.push_back(w[7:0]);
      stream.push_back(w[15:8]);
      stream.push_back(w[23:16]);
      stream.push_back(w[31:24]);
    end
    send_stream(1'b0);
    wait_end();
    chk("full_nwr", 32'(wr_addr.size()), 32'd256);
    chk("full_last_addr", get_addr(255), 32'h3FC);
    chk("full_last_data", get_data(255), 32'hC0DE_00FF);
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (get_addr(i) !== 32'(4 * i) || get_data(i) !== (32'hC0DE_0000 | 32'(i))) nbad++;
    end
    chk("full_all_words", 32'(nbad), 32'd0);
    chk("full_done", 32'(done), 32'd1);

    // start mid-LOAD is ignored
    new_load();
    stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_ready", 32'(byte_ready), 32'd1);
    chk("ign_done", 32'(done), 32'd0);
    stream = '{8'h66, 8'h77, 8'h88};
    send_stream(1'b0);
    wait_end();
    chk("ign_nwr", 32'(wr_addr.size()), 32'd2);
    chk("ign_data0", get_data(0), 32'h4433_2211);
    chk("ign_addr1", get_addr(1), 32'h4);
    chk("ign_data1", get_data(1), 32'h8877_6655);

    // Restart after DONE with a one-word load
    new_load();
    chk("re_done_clr", 32'(done), 32'd0);
    chk("re_cpu_rst", 32'(cpu_rst), 32'd1);
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(1'b0);
    wait_end();
    chk("re_nwr", 32'(wr_addr.size()), 32'd1);
    chk("re_addr0", get_addr(0), 32'h0);
    chk("re_data0", get_data(0), 32'hDEAD_BEEF);
    chk("re_done", 32'(done), 32'd1);

    // Reset after 5 payload bytes of a 3-word load
    new_load();
    stream = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_stream(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    chk("midrst_nwr", 32'(wr_addr.size()), 32'd1);
    chk("midrst_data0", get_data(0), 32'h0403_0201);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);

    chk("ready_low_in_write", 32'(ready_in_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot-load controller for the writable instruction memory of the single-cycle core.
- Accepts a byte stream from a host (UART receiver or testbench) carrying a 16-bit word-count header and then the program words.
- Assembles the words, writes them into instruction memory one word per write strobe, and holds the CPU in reset until the load has completed successfully.

Parameters:
- mem_size, 256, instruction memory depth in 32-bit words; the maximum accepted word count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- byte_valid  in  1  host presents a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  controller can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the word being written; always word-aligned, bits [1:0] = 0.
- mem_wdata  out  32  assembled instruction word.
- cpu_rst  out  1  holds the processor in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  last load completed successfully; sticky until the next start or rst.
- error  out  1  last load rejected; sticky until the next start or rst.

Behaviour:
- Reset: sets state IDLE, cpu_rst=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, and clears all internal counters. Reset mid-load abandons the load immediately, with no further writes.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_data is ignored otherwise. byte_ready is a registered function of state.
- States:
  - IDLE: byte_ready=0. start -> HDR0; clears done and error, sets busy=1, cpu_rst=1.
  - HDR0: byte_ready=1. Accepted byte -> count[7:0]; go to HDR1.
  - HDR1: byte_ready=1. Accepted byte -> count[15:8], then branch on the full count:
    - count == 0 -> DONE.
    - count > mem_size -> ERR.
    - otherwise -> LOAD with word_idx=0, byte_idx=0.
  - LOAD: byte_ready=1. Bytes assemble little-endian: byte_idx 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]. The 4th accepted byte moves to WRITE.
  - WRITE: lasts exactly one cycle.
    - mem_we=1, mem_wdata=assembled word, mem_addr={word_idx,2'b00} zero-extended to 32 bits, byte_ready=0.
    - Next state: DONE if word_idx == count-1, else increment word_idx, clear byte_idx, return to LOAD.
  - DONE: busy=0, done=1, cpu_rst=0 from the first DONE cycle; byte_ready=0.
  - ERR: busy=0, error=1, cpu_rst stays 1, byte_ready=0. No memory write occurs for a rejected header.
- Outputs outside WRITE: mem_we=0 in every state except WRITE. mem_addr and mem_wdata hold their last values.
- Throughput: at most 4 bytes per 5 cycles during LOAD; the host may stall byte_valid arbitrarily between bytes.
- start behaviour:
  - Honoured only in IDLE, DONE and ERR. A start from DONE or ERR restarts as from IDLE and re-asserts cpu_rst the next cycle.
  - Ignored in HDR0, HDR1, LOAD and WRITE.
  - start coinciding with rst: rst wins.
- Width rules: count is 16 bits and compared unsigned against mem_size. word_idx is wide enough for mem_size-1. A count of exactly mem_size is legal and fills the memory, with the last write at mem_addr=4*(mem_size-1).
- Bytes offered while byte_ready=0 are not consumed, so the host must hold them.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> cpu_rst=1, busy=0, done=0, error=0, mem_we=0. With no start, the state is unchanged for 20 cycles.
- Two-word load: start, then stream 02 00 13 05 A0 00 B3 05 B5 00 with valid held high -> exactly two mem_we pulses:
  - addr 0x0, data 0x00A00513.
  - addr 0x4, data 0x00B505B3.
  - Then done=1 and cpu_rst=0.
- Stalled host: same stream with byte_valid randomly low about 50% of the time -> identical writes and final state. No byte is consumed while byte_ready=0 in WRITE.
- Header bounds, with mem_size=256:
  - count 0x0101 (257) -> error=1, cpu_rst=1, no mem_we.
  - count 0x0000 -> done=1 with no writes.
  - count 0x0100 -> 256 writes, last at addr 0x3FC.
- Restart and ignore: start asserted mid-LOAD is ignored. A start after DONE clears done, re-asserts cpu_rst, and a new 1-word load writes to addr 0x0.
- Reset mid-load: assert rst after 5 payload bytes of a 3-word load -> the next cycle returns to the reset values. The second word is never written (exactly 1 mem_we pulse total).
